// File: rtl/clk_div_monitor.sv
// Divided-clock checker: measures period and high phase of clk_in in clk cycles and reports lock/err.
// Define CLK_DIV_MON_SYNC_EN to pass clk_in through a two-flop synchronizer (adds 2 cycles of latency).
module clk_div_monitor #(
    parameter int CNT_W    = 8,
    parameter int EXP_DIV  = 6,
    parameter int EXP_HIGH = 3,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_len,
    output logic             valid,
    output logic             locked,
    output logic             err
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] EXP_DIV_C  = CNT_W'(EXP_DIV);
    localparam logic [CNT_W-1:0] EXP_HIGH_C = CNT_W'(EXP_HIGH);
    localparam logic [MC_W-1:0]  LOCK_C     = MC_W'(LOCK_CNT);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t           state_r;
    logic             s_s;
    logic             s_q_r;
    logic             rise_s;
    logic             match_s;
    logic             timeout_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] hcnt_r;
    logic [MC_W-1:0]  match_cnt_r;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] high_len_r;
    logic             valid_r;
    logic             locked_r;
    logic             err_r;

`ifdef CLK_DIV_MON_SYNC_EN
    logic sync1_r;
    logic sync2_r;

    // Two-flop synchronizer for a clk_in coming from an unrelated domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= clk_in;
            sync2_r <= sync1_r;
        end
    end

    assign s_s = sync2_r;
`else
    assign s_s = clk_in;
`endif

    assign rise_s    = s_s & ~s_q_r;
    assign match_s   = (cnt_r == EXP_DIV_C) && (hcnt_r == EXP_HIGH_C);
    assign timeout_s = (cnt_r == CNT_MAX);

    // Edge history and saturating period / high-phase counters restarted on every rise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q_r  <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
            hcnt_r <= {CNT_W{1'b0}};
        end else begin
            s_q_r <= s_s;
            if (rise_s) begin
                cnt_r  <= CNT_W'(1);
                hcnt_r <= CNT_W'(1);
            end else begin
                if (cnt_r != CNT_MAX) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                if (s_s && (hcnt_r != CNT_MAX)) begin
                    hcnt_r <= hcnt_r + CNT_W'(1);
                end
            end
        end
    end

    // Measurement FSM: publishes results, tracks consecutive matches, flags mismatches and timeouts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            match_cnt_r <= {MC_W{1'b0}};
            period_r    <= {CNT_W{1'b0}};
            high_len_r  <= {CNT_W{1'b0}};
            valid_r     <= 1'b0;
            locked_r    <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    // The partial period before the first rise is never reported
                    if (rise_s) begin
                        state_r <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise_s) begin
                        period_r   <= cnt_r;
                        high_len_r <= hcnt_r;
                        valid_r    <= 1'b1;
                        if (match_s) begin
                            if (match_cnt_r != LOCK_C) begin
                                match_cnt_r <= match_cnt_r + MC_W'(1);
                            end
                            if (match_cnt_r >= (LOCK_C - MC_W'(1))) begin
                                locked_r <= 1'b1;
                            end
                        end else begin
                            match_cnt_r <= {MC_W{1'b0}};
                            locked_r    <= 1'b0;
                            err_r       <= 1'b1;
                        end
                    end else if (timeout_s) begin
                        // clk_in stuck: report once and wait for a fresh first edge
                        err_r       <= 1'b1;
                        locked_r    <= 1'b0;
                        match_cnt_r <= {MC_W{1'b0}};
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    match_cnt_r <= {MC_W{1'b0}};
                    locked_r    <= 1'b0;
                end
            endcase
        end
    end

    assign period   = period_r;
    assign high_len = high_len_r;
    assign valid    = valid_r;
    assign locked   = locked_r;
    assign err      = err_r;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Self-checking bench for clk_div_monitor: window-based reference model compared every cycle,
// plus hand-computed checkpoints per scenario.
module tb_clk_div_monitor;

    localparam int CNT_W    = 8;
    localparam int EXP_DIV  = 6;
    localparam int EXP_HIGH = 3;
    localparam int LOCK_CNT = 4;
    localparam int TMO      = 255;

    logic             clk    = 1'b0;
    logic             reset  = 1'b1;
    logic             clk_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_len;
    logic             valid;
    logic             locked;
    logic             err;

    int total = 0;
    int bad   = 0;

    clk_div_monitor #(
        .CNT_W(CNT_W), .EXP_DIV(EXP_DIV), .EXP_HIGH(EXP_HIGH), .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk(clk), .reset(reset), .clk_in(clk_in),
        .period(period), .high_len(high_len), .valid(valid), .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: samples since the last rise, expected outputs
    bit   m_sq, m_meas, m_d1, m_d2;
    bit   win[$];
    int   streak;
    int   e_period, e_high;
    bit   e_valid, e_locked, e_err;
    // Observations of the DUT for checkpoint pins
    int   cyc = 0, n_valid = 0, n_err = 0, lock_at = 0, last_valid_cyc = 0, last_err_cyc = 0;
    int   rises_driven = 0, first_valid_rises = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_sq = 0; m_meas = 0; m_d1 = 0; m_d2 = 0; win = {}; streak = 0;
                e_period = 0; e_high = 0; e_valid = 0; e_locked = 0; e_err = 0;
            end else begin
                bit s, rise;
                int p, h;
`ifdef CLK_DIV_MON_SYNC_EN
                s = m_d2; m_d2 = m_d1; m_d1 = clk_in;
`else
                s = clk_in;
`endif
                rise = s && !m_sq;
                m_sq = s;
                e_valid = 0;
                e_err   = 0;
                if (rise) begin
                    if (m_meas) begin
                        p = win.size();
                        h = 0;
                        foreach (win[i]) h += int'(win[i]);
                        e_period = p; e_high = h; e_valid = 1;
                        if (p == EXP_DIV && h == EXP_HIGH) begin
                            if (streak < LOCK_CNT) streak++;
                            if (streak == LOCK_CNT) e_locked = 1;
                        end else begin
                            streak = 0; e_locked = 0; e_err = 1;
                        end
                    end
                    m_meas = 1;
                    win = {};
                    win.push_back(1'b1);
                end else if (m_meas) begin
                    if (win.size() == TMO) begin
                        e_err = 1; e_locked = 0; streak = 0; m_meas = 0; win = {};
                    end else begin
                        win.push_back(s);
                    end
                end
            end
            #1;
            chk("period",   period,   e_period);
            chk("high_len", high_len, e_high);
            chk("valid",    valid,    e_valid);
            chk("locked",   locked,   e_locked);
            chk("err",      err,      e_err);
            if (valid === 1'b1) begin
                n_valid++;
                last_valid_cyc = cyc;
                if (first_valid_rises == 0) first_valid_rises = rises_driven;
            end
            if (err === 1'b1) begin
                n_err++;
                last_err_cyc = cyc;
            end
            if (locked === 1'b1 && lock_at == 0) lock_at = n_valid;
        end
    end

    // Drive n periods of a waveform that is high for hi of every per cycles
    task automatic drive_wave(input int per, input int hi, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < per; i++) begin
                @(negedge clk);
                if (i == 0 && hi > 0 && clk_in == 1'b0) rises_driven++;
                clk_in = (i < hi);
            end
        end
    endtask

    task automatic hold_low(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            clk_in = 1'b0;
        end
    endtask

    int v0, e0;

    initial begin
        #2 reset = 1'b0;

        // Lock on divide-by-6
        drive_wave(6, 3, 6);
        chk("s1_first_valid_edge", first_valid_rises, 2);
        chk("s1_lock_at_valid", lock_at, 4);
        chk("s1_err_count", n_err, 0);
        chk("s1_locked", locked, 1);
        chk("s1_period", period, 6);
        chk("s1_high", high_len, 3);

        // Wrong ratio: divide-by-4
        e0 = n_err;
        drive_wave(4, 2, 5);
        chk("s2_err_count", n_err - e0, 4);
        chk("s2_locked", locked, 0);
        chk("s2_period", period, 4);
        chk("s2_high", high_len, 2);

        // Duty error then recovery
        e0 = n_err;
        drive_wave(6, 2, 3);
        chk("s3_err_count", n_err - e0, 3);
        chk("s3_period", period, 6);
        chk("s3_high", high_len, 2);
        chk("s3_locked", locked, 0);
        e0 = n_err;
        drive_wave(6, 3, 6);
        chk("s3_relock_err", n_err - e0, 1);
        chk("s3_relocked", locked, 1);

        // Stuck input: one timeout err, values held
        e0 = n_err;
        hold_low(300);
        chk("s4_timeout_err", n_err - e0, 1);
        chk("s4_timeout_dist", last_err_cyc - last_valid_cyc, TMO);
        chk("s4_locked", locked, 0);
        chk("s4_period_hold", period, 6);
        chk("s4_high_hold", high_len, 3);
        v0 = n_valid; e0 = n_err;
        drive_wave(6, 3, 6);
        chk("s4_restart_valids", n_valid - v0, 5);
        chk("s4_restart_err", n_err - e0, 0);
        chk("s4_relocked", locked, 1);

        // Asynchronous reset between clk edges while locked
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("s5_rst_period", period, 0);
        chk("s5_rst_high", high_len, 0);
        chk("s5_rst_valid", valid, 0);
        chk("s5_rst_locked", locked, 0);
        chk("s5_rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        v0 = n_valid; e0 = n_err;
        drive_wave(6, 3, 3);
        chk("s5_post_valids", n_valid - v0, 2);
        chk("s5_post_err", n_err - e0, 0);
        chk("s5_post_locked", locked, 0);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Receive-side checker for divided clocks produced by the team's clock-divider blocks, such as the divide-by-6 generator. It samples a divided clock in the fast clock domain and measures each period and high phase in fast-clock cycles. It compares every measurement against the expected ratio and reports lock status and error pulses. It sits beside the divider in the clock-generation area and feeds status to the bench and to any logic that must not start before the divided clock is stable.

## Interface
- `CNT_W`, default 8: width of the measurement counters and of the `period` and `high_len` outputs.
- `EXP_DIV`, default 6: expected period in `clk` cycles.
- `EXP_HIGH`, default 3: expected high phase in `clk` cycles.
- `LOCK_CNT`, default 4: number of consecutive matching periods required to assert `locked`.
- `clk` input 1: fast reference clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `clk_in` input 1: divided clock under test, sampled as data in the `clk` domain.
- `period` output CNT_W: `clk` cycles between the last two `clk_in` rising edges.
- `high_len` output CNT_W: `clk` cycles `clk_in` was sampled high within that period.
- `valid` output 1: one-cycle pulse; `period` and `high_len` were updated.
- `locked` output 1: level; the last `LOCK_CNT` measurements all matched.
- `err` output 1: one-cycle pulse on a mismatched measurement or a timeout.

## Operation
- Sampling:
  - `s` is `clk_in`, or the synchronizer output when the macro is defined.
  - `s_q` is `s` registered.
  - `rise = s & ~s_q`.
- Counters:
  - On `rise`: `cnt <= 1`; otherwise `cnt <= cnt + 1`, saturating at `2^CNT_W-1`.
  - On `rise`: `hcnt <= 1`; otherwise `hcnt <= hcnt + s`, saturating.
  - In a rise cycle, `cnt` therefore equals the true period P.
  - In a rise cycle, `hcnt` equals the number of high samples over the previous P cycles.
- FSM states: `IDLE` and `MEASURE`.
  - `IDLE`: waits for the first `rise` and moves to `MEASURE`. No `valid` is produced for this partial period.
  - `MEASURE`, on `rise`:
    - `period <= cnt`, `high_len <= hcnt`, and `valid` pulses.
    - Match means `cnt == EXP_DIV && hcnt == EXP_HIGH`.
    - On a match, `match_cnt` increments, saturating at `LOCK_CNT`. `locked <= 1` when it reaches `LOCK_CNT`.
    - On a mismatch: `match_cnt <= 0`, `locked <= 0`, `err` pulses, and the FSM stays in `MEASURE`.
  - `MEASURE`, timeout: when `cnt == 2^CNT_W-1` with no `rise` (`clk_in` stuck):
    - `err` pulses once.
    - `locked <= 0` and `match_cnt <= 0`.
    - FSM returns to `IDLE`; `period` and `high_len` hold their values.
  - A timeout and a `rise` in the same cycle: the `rise` wins and is measured normally.
- Arithmetic: compares are unsigned and CNT_W bits wide. `EXP_DIV` and `EXP_HIGH` must be at most `2^CNT_W-2`.

## Timing
- Reset values: `period`, `high_len`, `valid`, `locked` and `err` are all 0; FSM is `IDLE`; all counters and `s_q` are 0.
- Reset asserted mid-measurement clears everything asynchronously. The first period after reset release is discarded.
- All outputs are registered. `valid` and `err` assert in the cycle after the rise cycle and last exactly one cycle.
- Latency from a `clk_in` rising edge to `valid` is 1 `clk` cycle: `clk_in` is itself a flop output in the `clk` domain.
- `locked` rises together with the `valid` of the `LOCK_CNT`-th consecutive match. It falls together with the first `err`.
- For a steady divided clock, `valid` pulses exactly every `EXP_DIV` cycles.

## Configuration
- `CLK_DIV_MON_SYNC_EN` defined:
  - `clk_in` passes through a two-flop synchronizer before `s`.
  - All edge-to-output latencies grow by 2 cycles.
  - Measured values are unchanged.
  - Use this for `clk_in` from an unrelated domain.
- Not defined: `clk_in` is used directly; latency is 1 cycle.

## Test plan
- Lock on divide-by-6:
  - Stimulus: reset for 2 ns, then a 50% divide-by-6 `clk_in`.
  - Response: first `valid` on the second rising edge, with `period=6` and `high_len=3`.
  - `locked=1` with the 4th `valid`; `err` never asserts.
- Wrong ratio:
  - Stimulus: divide-by-4 waveform.
  - Response: every `valid` carries `period=4`, `high_len=2` and an `err` pulse; `locked` stays 0.
- Duty error:
  - Stimulus: period 6 with 2 high cycles.
  - Response: `period=6`, `high_len=2`, `err` pulses, no lock.
  - Switching to the correct waveform gives `locked=1` after 4 good periods.
- Stuck input:
  - Stimulus: while locked, hold `clk_in=0`.
  - Response: exactly one `err` pulse 255 cycles after the last rise, `locked` falls, FSM returns to `IDLE`.
  - Restarting the divide-by-6 waveform relocks after 5 rising edges.
- Reset mid-operation:
  - Stimulus: assert `reset` asynchronously between `clk` edges while locked.
  - Response: all outputs are 0 immediately; after release the first partial period produces no `valid`.
- Sync macro:
  - Stimulus: repeat the first scenario with `CLK_DIV_MON_SYNC_EN` defined.
  - Response: identical values, with every pulse delayed by 2 cycles.
